// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD accumulator and its digit adder.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  function automatic logic digit_invalid(input bcd_digit_t d);
    return d > bcd_digit_t'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_accum_if.sv
// Operand/result bundle for bcd_serial_accum.
// Both channels are valid/ready: a transfer happens on a rising edge where valid && ready
// are both high; the producer holds its payload stable while valid is high and ready is low.
interface bcd_serial_accum_if #(
  parameter int NDIGITS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   sum;
  logic                   cout;
  logic                   err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Optional macro BCD_DIGIT_CHECK_EN enables the invalid-digit flag; otherwise it is tied low.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       c_i,
  output bcd_digit_t sum_o,
  output logic       c_o,
  output logic       invalid_o
);

  logic [4:0] t;

  // (t+6)[3:0] equals t[3:0]+6 modulo 16, so the correction stays 4 bits wide.
  always_comb begin
    t     = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
    c_o   = (t > 5'(BCD_MAX));
    sum_o = c_o ? (t[3:0] + 4'(BCD_CORR)) : t[3:0];
  end

`ifdef BCD_DIGIT_CHECK_EN
  assign invalid_o = digit_invalid(a_i) | digit_invalid(b_i);
`else
  assign invalid_o = 1'b0;
`endif

endmodule

// File: rtl/bcd_serial_accum.sv
// Digit-serial BCD adder: accepts two packed operands, adds one digit per cycle LSD first.
// Optional macro BCD_DIGIT_CHECK_EN builds the sticky invalid-digit flag on err.
module bcd_serial_accum
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_accum_if.slave   bus,
  output state_e              dbg_state_o
);

  localparam int              CNT_W = $clog2(NDIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);

  state_e                    state_q;
  bcd_digit_t [NDIGITS-1:0]  a_q;
  bcd_digit_t [NDIGITS-1:0]  b_q;
  bcd_digit_t [NDIGITS-1:0]  sum_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      carry_q;
  logic                      cout_q;

  bcd_digit_t                a_dig_d;
  bcd_digit_t                b_dig_d;
  bcd_digit_t                dig_d;
  logic                      carry_d;
  logic                      dig_inv_d;

  logic                      accept;
  assign accept = (state_q == IDLE) && bus.in_valid;

  // Explicit decode keeps the counter free of index-width coupling for any NDIGITS.
  always_comb begin
    a_dig_d = '0;
    b_dig_d = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig_d = a_q[i];
        b_dig_d = b_q[i];
      end
    end
  end

  bcd_digit_add u_digit_add (
    .a_i       (a_dig_d),
    .b_i       (b_dig_d),
    .c_i       (carry_q),
    .sum_o     (dig_d),
    .c_o       (carry_d),
    .invalid_o (dig_inv_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) sum_q[i] <= dig_d;
          end
          carry_q <= carry_d;
          if (cnt_q == LAST) begin
            cout_q  <= carry_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q;

  // Sticky across the whole transaction; only a new acceptance clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state_q == ADD) && dig_inv_d) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_dig_inv;
  logic unused_accept;
  assign unused_dig_inv = dig_inv_d;
  assign unused_accept  = accept;
  assign bus.err        = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bcd_serial_accum.sv
// Self-checking bench for bcd_serial_accum: directed corner cases plus randomized traffic
// against an integer-arithmetic reference model, checked by a decoupled output monitor.
module tb_bcd_serial_accum;
  import bcd_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4 * N;
  localparam int W  = DW + 2;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  logic [W-1:0] exp_q[$];
  longint       acc_t_q[$];
  int           hold_low = 0;
  bit           rand_bp  = 1'b0;

  bcd_serial_accum_if #(.NDIGITS(N)) bus ();

  bcd_serial_accum #(.NDIGITS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got timeout/absent expected event within bound", name);
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint unsigned bcd_val(input logic [DW-1:0] v);
    longint unsigned r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + 64'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic cin);
    longint unsigned total;
    longint unsigned lim;
    longint unsigned r;
    logic [DW-1:0]   s;
    logic            bad;
    lim   = pow10(N);
    total = bcd_val(a) + bcd_val(b) + 64'(cin);
    r     = total % lim;
    bad   = 1'b0;
    for (int i = 0; i < N; i++) begin
      s[4*i +: 4] = 4'(r % 10);
      r = r / 10;
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return {bad & ERR_EN, total >= lim, s};
  endfunction

  function automatic logic [DW-1:0] rand_bcd();
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                      input logic [W-1:0] exp, input bit track);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      fail("accept_timeout");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (track) begin
        exp_q.push_back(exp);
        acc_t_q.push_back(longint'($time));
      end
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.in_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) fail("drain_timeout");
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0) begin
        bus.out_ready = 1'b0;
        hold_low--;
      end else if (rand_bp) begin
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] held;
  logic [W-1:0] got;
  bit           pending = 1'b0;
  longint       t0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else if (bus.out_valid) begin
      got = {bus.err, bus.cout, bus.sum};
      check("in_ready_in_done", 64'(bus.in_ready), 64'(0));
      if (pending) begin
        check("hold_stable", 64'(got), 64'(held));
      end else if (acc_t_q.size() == 0) begin
        fail("unexpected_result");
      end else begin
        t0 = acc_t_q.pop_front();
        check("latency", 64'((longint'($time) - t0 - 5) / 10), 64'(N));
      end
      if (bus.out_ready) begin
        if (exp_q.size() == 0) fail("no_expected_entry");
        else check("result", 64'(got), 64'(exp_q.pop_front()));
        pending = 1'b0;
      end else begin
        pending = 1'b1;
        held    = got;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    fail("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;
  logic          rc;

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_cout", 64'(bus.cout), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;

    // basic add and latency
    send(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}, 1'b1);
    wait_idle();

    // maximum-carry boundaries
    send(16'h9999, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h0000}, 1'b1);
    send(16'h9999, 16'h9999, 1'b1, {1'b0, 1'b1, 16'h9999}, 1'b1);
    wait_idle();

    // back-pressure: out_ready low for the first 5 DONE cycles
    hold_low = 10;
    send(16'h0058, 16'h0067, 1'b0, {1'b0, 1'b0, 16'h0125}, 1'b1);
    wait_idle();

    // in_valid with other operands during ADD is ignored
    send(16'h2468, 16'h1357, 1'b1, {1'b0, 1'b0, 16'h3826}, 1'b1);
    bus.a        = 16'h9999;
    bus.b        = 16'h9999;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_idle();

    // reset during the second ADD cycle discards the transaction
    send(16'h1111, 16'h2222, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    check("partial_digit0", 64'(bus.sum), 64'(16'h0003));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_sum", 64'(bus.sum), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    check("midrst_cout", 64'(bus.cout), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'h0499, 16'h0501, 1'b0, {1'b0, 1'b0, 16'h1000}, 1'b1);
    wait_idle();

    // invalid digit: err only when checking is built
    send(16'h00A1, 16'h0001, 1'b0, {ERR_EN, 1'b0, 16'h0102}, 1'b1);
    wait_idle();
    send(16'h0001, 16'h0002, 1'b0, {1'b0, 1'b0, 16'h0003}, 1'b1);
    wait_idle();

    // randomized traffic with random back-pressure
    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 7) begin
        ra = 16'h9999;
        rb = rand_bcd();
      end else begin
        ra = rand_bcd();
        rb = rand_bcd();
      end
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc), 1'b1);
    end
    wait_idle();
    rand_bp = 1'b0;

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("acc_drained", 64'(acc_t_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
